// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizing constants and streamer state encoding
package cnn_pkg;
  localparam int N_OUT = 16;
  localparam int DW = 16;
  localparam int CLS_W = $clog2(N_OUT);
  typedef enum logic [1:0] {IDLE, STREAM, CLASS} state_t;
endpackage

// File: rtl/argmax_tracker.sv
// argmax_tracker: running signed maximum with lowest-index tie break
module argmax_tracker
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [CLS_W-1:0]        idx,
  input  logic signed [DW-1:0]    val,
  output logic [CLS_W-1:0]        best_idx,
  output logic signed [DW-1:0]    best_val
);
  // element 0 always seeds the best; later elements win only when strictly greater
  always_ff @(posedge clk)
    if (rst || clr) begin
      best_idx <= '0;
      best_val <= '0;
    end else if (en && (idx == '0 || val > best_val)) begin
      best_idx <= idx;
      best_val <= val;
    end
endmodule

// File: rtl/result_streamer.sv
// result_streamer: captures a score frame and streams scores plus winning class index
module result_streamer
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [N_OUT*DW-1:0]   in_data,
  output logic                  in_ready,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data,
  output logic                  m_last,
  output logic                  overflow
);
  state_t state, nxt;
  logic [DW-1:0] frame [N_OUT];
  logic [CLS_W-1:0] idx, best_idx;
  logic hs, cap, last_el;
  assign hs = m_valid && m_ready;
  assign cap = state == IDLE && in_valid && !rst;
  assign last_el = idx == CLS_W'(N_OUT - 1);
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state: a frame starts streaming, scores advance on handshakes, class word ends it
  always_comb
    nxt = state == IDLE   ? (in_valid ? STREAM : IDLE) :
          state == STREAM ? (hs && last_el ? CLASS : STREAM) :
                            (hs ? IDLE : CLASS);
  // outputs are pure functions of state and index so they hold while stalled
  always_comb begin
    in_ready = state == IDLE;
    m_valid = state != IDLE;
    m_last = state == CLASS;
    m_data = state == STREAM ? frame[idx] : state == CLASS ? DW'(best_idx) : '0;
  end
  // frame buffer is only written on capture; IDLE masks its stale contents
  always_ff @(posedge clk)
    if (cap)
      for (int k = 0; k < N_OUT; k++) frame[k] <= in_data[k*DW +: DW];
  // element index and sticky drop flag
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap) idx <= '0;
      else if (state == STREAM && hs && !last_el) idx <= idx + 1'b1;
      if (in_valid && state != IDLE) overflow <= 1'b1;
    end
  argmax_tracker u_argmax (
    .clk(clk),
    .rst(rst),
    .clr(cap),
    .en(state == STREAM && hs),
    .idx(idx),
    .val(frame[idx]),
    .best_idx(best_idx),
    .best_val()
  );
endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: directed checks of capture, streaming, argmax, drops and reset
module tb_result_streamer;
  import cnn_pkg::*;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, m_ready = 1'b0;
  logic [N_OUT*DW-1:0] in_data = '0;
  logic in_ready, m_valid, m_last, overflow;
  logic [DW-1:0] m_data;
  logic [DW-1:0] sc [N_OUT];
  int vecs = 0, errs = 0;
  int cls_tab [3] = '{2, 7, 13};
  result_streamer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send();
    in_valid = 1'b1;
    for (int k = 0; k < N_OUT; k++) in_data[k*DW +: DW] = sc[k];
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic recv(input int cls, input int mode, input int drop_at, input int stop_k);
    int k = 0;
    int cyc = 0;
    while (k < stop_k && cyc < 200) begin
      m_ready = (mode == 0) || (cyc % 3 == 0);
      in_valid = cyc == drop_at;
      if (cyc == drop_at) begin
        in_data = {N_OUT{16'hAAAA}};
        chk("drop_in_ready", {31'b0, in_ready}, 0);
      end
      if (drop_at >= 0 && cyc > drop_at) chk("overflow_set", {31'b0, overflow}, 1);
      chk("m_valid", {31'b0, m_valid}, 1);
      chk("m_data", {16'b0, m_data}, k < N_OUT ? {16'b0, sc[k]} : 32'(cls));
      chk("m_last", {31'b0, m_last}, {31'b0, k == N_OUT});
      if (m_ready) k++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (k < stop_k) chk("timeout", k, stop_k);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_m_valid", {31'b0, m_valid}, 0);
    chk("rst_m_last", {31'b0, m_last}, 0);
    chk("rst_m_data", {16'b0, m_data}, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready_m_valid", {31'b0, m_valid}, 0);
    chk("idle_ready_in_ready", {31'b0, in_ready}, 1);
    m_ready = 1'b0;
    for (int k = 0; k < N_OUT; k++) sc[k] = 16'(k * 10);
    send();
    recv(15, 0, -1, N_OUT + 1);
    chk("basic_in_ready", {31'b0, in_ready}, 1);
    chk("basic_m_valid", {31'b0, m_valid}, 0);
    chk("basic_overflow", {31'b0, overflow}, 0);
    for (int k = 0; k < N_OUT; k++) sc[k] = 16'hFFF0;
    sc[3] = 16'h0005;
    sc[9] = 16'h0005;
    send();
    recv(3, 0, -1, N_OUT + 1);
    for (int k = 0; k < N_OUT; k++) sc[k] = 16'(100 - k * 3);
    send();
    recv(0, 1, -1, N_OUT + 1);
    chk("bp_in_ready", {31'b0, in_ready}, 1);
    for (int k = 0; k < N_OUT; k++) sc[k] = k == 11 ? 16'd500 : 16'(k);
    send();
    recv(11, 0, 4, N_OUT + 1);
    chk("ovf_sticky", {31'b0, overflow}, 1);
    for (int k = 0; k < N_OUT; k++) sc[k] = 16'(k * 10);
    send();
    recv(15, 0, -1, N_OUT + 1);
    chk("ovf_still_set", {31'b0, overflow}, 1);
    send();
    recv(15, 0, -1, 7);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = {N_OUT{16'h5555}};
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_m_valid", {31'b0, m_valid}, 0);
    chk("midrst_overflow", {31'b0, overflow}, 0);
    chk("midrst_m_data", {16'b0, m_data}, 0);
    chk("midrst_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    chk("rst_wins_m_valid", {31'b0, m_valid}, 0);
    send();
    recv(15, 0, -1, N_OUT + 1);
    chk("pre_coinc_overflow", {31'b0, overflow}, 0);
    send();
    recv(15, 0, N_OUT, N_OUT + 1);
    chk("coinc_overflow", {31'b0, overflow}, 1);
    chk("coinc_m_valid", {31'b0, m_valid}, 0);
    chk("coinc_in_ready", {31'b0, in_ready}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N_OUT; k++) sc[k] = k == cls_tab[f] ? 16'h0100 : 16'(k + f);
      send();
      recv(cls_tab[f], 0, -1, N_OUT + 1);
    end
    chk("b2b_overflow", {31'b0, overflow}, 0);
    chk("b2b_in_ready", {31'b0, in_ready}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/result_streamer.md
# result_streamer

Terminal stage of the CNN datapath: sits directly after the final classification layer and is the reading end of its one-cycle `out_valid` / parallel `out` interface. On each result pulse it captures all N_OUT class scores and serialises them onto a valid/ready word stream toward the PS/DMA. During streaming it computes the winning class index and appends that index as a final, `m_last`-tagged word. Frames that arrive while a stream is still in progress are dropped and flagged, because the layer pipeline cannot be stalled.

## Interface
- `N_OUT`, 16: number of class scores per result frame.
- `DW`, 16: score width in bits. Scores are two's-complement signed.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one-cycle pulse from the last layer; `in_data` is valid in that cycle.
- `in_data`  in  N_OUT*DW  packed scores. Element k occupies bits [k*DW +: DW]; element 0 is at the LSBs.
- `in_ready`  out  1  high when the block is in IDLE, i.e. a pulse this cycle will be captured.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DW  stream word.
- `m_last`  out  1  high on the final (class index) word of a frame.
- `overflow`  out  1  sticky. Set when a frame is dropped; cleared only by `rst`.

## Operation
- FSM states:
  - IDLE: wait for a frame.
  - STREAM: send the N_OUT scores.
  - CLASS: send the class index.
- IDLE → STREAM: on `in_valid`=1. On the same edge:
  - register all of `in_data` into the frame buffer;
  - set element index `idx` = 0;
  - clear `best_val` and `best_idx`.
- STREAM:
  - `m_data` = buffer[`idx`], `m_valid`=1, `m_last`=0.
  - On each handshake (`m_valid & m_ready`):
    - update argmax with element `idx`;
    - if `idx` = N_OUT-1, go to CLASS; otherwise increment `idx`.
- Argmax rule:
  - Element 0 always loads `best_val` / `best_idx`.
  - Element k>0 replaces the current best only if it is strictly greater (signed compare).
  - On ties the lowest index wins.
- CLASS:
  - `m_data` = `best_idx`, zero-extended to DW bits; `m_valid`=1, `m_last`=1.
  - On handshake → IDLE.
- Drops: `in_valid`=1 in any state other than IDLE discards that frame and sets `overflow`. The frame being streamed is unaffected.
- Hold rule: while `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable and `m_valid` does not drop.
- `m_valid` never depends combinationally on `m_ready`.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `m_valid`=0, `m_last`=0, `m_data`=0, `overflow`=0, `idx`=0.
- Latency: `in_valid` at edge T → `m_valid`=1 with element 0 from cycle T+1.
- Throughput with `m_ready` held at 1:
  - N_OUT+1 consecutive words, one per cycle;
  - `m_last` on word N_OUT;
  - IDLE (`in_ready`=1) on the cycle after the last handshake.
- Minimum frame spacing accepted without loss: N_OUT+2 cycles (18 at defaults).
- `in_valid` coincident with the final CLASS handshake: dropped, `overflow`=1. `in_ready` is 0 in that cycle.
- `rst` mid-frame:
  - next cycle: state=IDLE and `m_valid`=0;
  - the buffered frame is discarded;
  - `overflow` is cleared.
- `rst` and `in_valid` in the same cycle: `rst` wins and nothing is captured.
- `m_ready`=1 while `m_valid`=0: no effect.

## Structure
- Shared package `cnn_pkg` holds:
  - `N_OUT`, `DW`;
  - `CLS_W = $clog2(N_OUT)`;
  - the state enum (IDLE, STREAM, CLASS).
- Sub-module `argmax_tracker`:
  - inputs: `clk`, `rst`, `clr`, `en`, `idx`, `val`;
  - outputs: `best_idx`, `best_val`;
  - holds the signed compare and the tie rule.
- Top of the block: frame buffer, `idx` counter, FSM, output mux.

## Test plan
- Basic frame:
  - Stimulus: scores = k*10 for k=0..15, `m_ready`=1.
  - Required: `m_data` 0,10,…,150 on consecutive cycles, then word 15 with `m_last`=1. `in_ready` returns to 1 the following cycle.
- Signed compare and tie:
  - Stimulus: all scores 0xFFF0 (-16) except element 3 = 0x0005 and element 9 = 0x0005.
  - Required: class word = 3.
- Backpressure:
  - Stimulus: toggle `m_ready` 1,0,0,1,…
  - Required: `m_data` stays stable while stalled. All 17 words arrive in order, with no duplicates and no skips.
- Overflow:
  - Stimulus: second `in_valid` 5 cycles after the first.
  - Required: `overflow` rises the next cycle and stays high. The first frame streams intact. A third pulse sent after the CLASS word completes is captured normally.
- Reset mid-stream:
  - Stimulus: assert `rst` after 7 handshakes.
  - Required: `m_valid`=0 and `overflow`=0 on the next cycle. A new frame afterwards starts again at element 0.
- Back-to-back at minimum spacing:
  - Stimulus: frames every 18 cycles with `m_ready`=1.
  - Required: every frame is fully streamed and `overflow` stays 0.
